// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and constants for the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    // Widest address/data the request struct carries; ports narrower than
    // this are zero-extended into it and sliced back out at the memory side.
    localparam int REQ_ADDR_W = 64;
    localparam int REQ_DATA_W = 64;

    localparam int PORT_CORE = 0;
    localparam int PORT_DMA  = 1;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                  write;
        logic [2:0]            funct3;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
    } dmem_req_t;

endpackage

`default_nettype wire

// File: rtl/dmem_arb_prio.sv
// ============================================================================
// Module      : dmem_arb_prio
// Description : Combinational grant decision between core and DMA ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arb_prio
    import dmem_arb_pkg::*;
(
    input  logic       c_valid,
    input  logic       d_valid,
    input  logic       hold_sat,
    input  arb_state_t state,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (state == LOCK) begin
            grant[PORT_DMA] = d_valid;
        end else if (c_valid && d_valid) begin
            // Core wins unless DMA has already waited through MAX_HOLD core beats.
            if (hold_sat) begin
                grant[PORT_DMA] = 1'b1;
            end else begin
                grant[PORT_CORE] = 1'b1;
            end
        end else begin
            grant[PORT_CORE] = c_valid;
            grant[PORT_DMA]  = d_valid;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares data_mem64 between core load/store path and a DMA
//               port; core priority with a DMA starvation bound.
//               Optional DMA lock feature: define DMEM_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req_valid,
    output logic              c_req_ready,
    input  logic              c_req_write,
    input  logic [2:0]        c_req_funct3,
    input  logic [ADDR_W-1:0] c_req_addr,
    input  logic [DATA_W-1:0] c_req_wdata,
    output logic              c_rsp_valid,
    output logic [DATA_W-1:0] c_rsp_rdata,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_write,
    input  logic [2:0]        d_req_funct3,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_rdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic              d_req_lock,
`endif
    output logic              m_memread,
    output logic              m_memwrite,
    output logic [2:0]        m_funct3,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic [1:0]        grant
);

    localparam int             c_cnt_w    = $clog2(MAX_HOLD + 1);
    localparam logic [c_cnt_w-1:0] c_hold_max = c_cnt_w'(MAX_HOLD);

    logic               r_rst_q;
    logic               w_block;
    logic [c_cnt_w-1:0] r_hold_cnt;
    arb_state_t         w_state;
    logic [1:0]         w_grant;
    logic               w_c_valid;
    logic               w_d_valid;
    logic               w_hold_sat;
    dmem_req_t          w_c_req;
    dmem_req_t          w_d_req;
    dmem_req_t          w_sel;
    logic               r_c_rsp_valid;
    logic               r_d_rsp_valid;
    logic [DATA_W-1:0]  r_c_rsp_rdata;
    logic [DATA_W-1:0]  r_d_rsp_rdata;

    // Outputs stay quiet during reset and for one cycle after it.
    always_ff @(posedge clk) begin
        r_rst_q <= rst;
    end

    assign w_block    = rst | r_rst_q;
    assign w_c_valid  = c_req_valid & ~w_block;
    assign w_d_valid  = d_req_valid & ~w_block;
    assign w_hold_sat = (r_hold_cnt == c_hold_max);

    dmem_arb_prio u_prio (
        .c_valid  (w_c_valid),
        .d_valid  (w_d_valid),
        .hold_sat (w_hold_sat),
        .state    (w_state),
        .grant    (w_grant)
    );

`ifdef DMEM_ARB_LOCK_EN
    arb_state_t r_state;
    arb_state_t w_state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_grant[PORT_DMA]) begin
            w_state_nxt = d_req_lock ? LOCK : ARB;
        end
    end

    assign w_state = r_state;
`else
    assign w_state = ARB;
`endif

    always_comb begin
        w_c_req = '{write:  c_req_write,
                    funct3: c_req_funct3,
                    addr:   REQ_ADDR_W'(c_req_addr),
                    wdata:  REQ_DATA_W'(c_req_wdata)};
        w_d_req = '{write:  d_req_write,
                    funct3: d_req_funct3,
                    addr:   REQ_ADDR_W'(d_req_addr),
                    wdata:  REQ_DATA_W'(d_req_wdata)};
        w_sel   = '0;
        if (w_grant[PORT_CORE]) begin
            w_sel = w_c_req;
        end else if (w_grant[PORT_DMA]) begin
            w_sel = w_d_req;
        end
    end

    assign m_memread   = (|w_grant) & ~w_sel.write;
    assign m_memwrite  = (|w_grant) &  w_sel.write;
    assign m_funct3    = w_sel.funct3;
    assign m_addr      = w_sel.addr[ADDR_W-1:0];
    assign m_wdata     = w_sel.wdata[DATA_W-1:0];
    assign grant       = w_grant;
    assign c_req_ready = w_grant[PORT_CORE];
    assign d_req_ready = w_grant[PORT_DMA];

    // Counts core beats won while DMA waits; frozen while DMA holds a lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= '0;
        end else if (w_state == ARB) begin
            if (w_grant[PORT_DMA] || !d_req_valid) begin
                r_hold_cnt <= '0;
            end else if (w_grant[PORT_CORE] && !w_hold_sat) begin
                r_hold_cnt <= r_hold_cnt + c_cnt_w'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_rsp_valid <= 1'b0;
            r_d_rsp_valid <= 1'b0;
            r_c_rsp_rdata <= '0;
            r_d_rsp_rdata <= '0;
        end else begin
            r_c_rsp_valid <= w_grant[PORT_CORE];
            r_d_rsp_valid <= w_grant[PORT_DMA];
            r_c_rsp_rdata <= (w_grant[PORT_CORE] && !w_sel.write) ? m_rdata : '0;
            r_d_rsp_rdata <= (w_grant[PORT_DMA]  && !w_sel.write) ? m_rdata : '0;
        end
    end

    assign c_rsp_valid = r_c_rsp_valid & ~w_block;
    assign d_rsp_valid = r_d_rsp_valid & ~w_block;
    assign c_rsp_rdata = w_block ? '0 : r_c_rsp_rdata;
    assign d_rsp_rdata = w_block ? '0 : r_d_rsp_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Randomized scoreboard bench for dmem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam int MAX_HOLD = 8;
`ifdef DMEM_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    typedef struct packed {
        logic        write;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
    } tb_req_t;

    typedef struct {
        int          due;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c_req_valid = 1'b0, c_req_ready, c_req_write = 1'b0;
    logic [2:0]  c_req_funct3 = '0;
    logic [63:0] c_req_addr = '0, c_req_wdata = '0;
    logic        c_rsp_valid;
    logic [63:0] c_rsp_rdata;
    logic        d_req_valid = 1'b0, d_req_ready, d_req_write = 1'b0;
    logic [2:0]  d_req_funct3 = '0;
    logic [63:0] d_req_addr = '0, d_req_wdata = '0;
    logic        d_rsp_valid;
    logic [63:0] d_rsp_rdata;
    logic        d_req_lock = 1'b0;
    logic        m_memread, m_memwrite;
    logic [2:0]  m_funct3;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  grant;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_write(c_req_write),
        .c_req_funct3(c_req_funct3), .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata),
        .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_write(d_req_write),
        .d_req_funct3(d_req_funct3), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
`ifdef DMEM_ARB_LOCK_EN
        .d_req_lock(d_req_lock),
`endif
        .m_memread(m_memread), .m_memwrite(m_memwrite), .m_funct3(m_funct3),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .grant(grant)
    );

    // Memory image: unwritten words read as a fixed pattern of their index.
    function automatic logic [63:0] init_val(input int i);
        return {32'hDEADBEEF, 32'(i - 1)};
    endfunction

    logic [63:0] pmem [64];
    logic        pwr  [64];
    logic [5:0]  ridx;
    assign ridx    = m_addr[8:3];
    assign m_rdata = pwr[ridx] ? pmem[ridx] : init_val(int'(ridx));

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) pwr[i] <= 1'b0;
        end else if (m_memwrite) begin
            pmem[m_addr[8:3]] <= m_wdata;
            pwr[m_addr[8:3]]  <= 1'b1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state.
    logic [63:0] rmem [64];
    exp_t        cq[$];
    exp_t        dq[$];
    int          m_hold   = 0;
    bit          m_lock   = 1'b0;
    bit          prev_rst = 1'b1;

    task automatic step(input logic r, input logic cv, input tb_req_t c,
                        input logic dv, input tb_req_t d, input logic lk);
        int      win;
        bit      blk;
        tb_req_t sel;
        exp_t    e;
        @(posedge clk);
        #1;
        rst          = r;
        c_req_valid  = cv;
        c_req_write  = c.write;
        c_req_funct3 = c.f3;
        c_req_addr   = c.addr;
        c_req_wdata  = c.wdata;
        d_req_valid  = dv;
        d_req_write  = d.write;
        d_req_funct3 = d.f3;
        d_req_addr   = d.addr;
        d_req_wdata  = d.wdata;
        d_req_lock   = lk;
        #2;
        blk = r || prev_rst;
        win = 0;
        if (!blk) begin
            if (m_lock)        win = dv ? 2 : 0;
            else if (cv && dv) win = (m_hold >= MAX_HOLD) ? 2 : 1;
            else if (cv)       win = 1;
            else if (dv)       win = 2;
        end
        sel = (win == 1) ? c : (win == 2) ? d : '0;
        check("grant",      64'(grant),       64'({win == 2, win == 1}));
        check("c_ready",    64'(c_req_ready), 64'(win == 1));
        check("d_ready",    64'(d_req_ready), 64'(win == 2));
        check("m_memread",  64'(m_memread),   64'(win != 0 && !sel.write));
        check("m_memwrite", 64'(m_memwrite),  64'(win != 0 && sel.write));
        check("m_funct3",   64'(m_funct3),    64'(sel.f3));
        check("m_addr",     m_addr,           sel.addr);
        check("m_wdata",    m_wdata,          sel.wdata);
        if (blk) begin
            check("rst_c_rsp_valid", 64'(c_rsp_valid), 64'(0));
            check("rst_d_rsp_valid", 64'(d_rsp_valid), 64'(0));
            check("rst_c_rsp_rdata", c_rsp_rdata, 64'(0));
        end
        if (r) begin
            cq.delete();
            dq.delete();
            m_hold = 0;
            m_lock = 1'b0;
            for (int i = 0; i < 64; i++) rmem[i] = init_val(i);
        end else begin
            if (win != 0) begin
                e.due  = cyc + 1;
                e.data = sel.write ? 64'd0 : rmem[sel.addr[8:3]];
                if (sel.write) rmem[sel.addr[8:3]] = sel.wdata;
                if (win == 1) cq.push_back(e);
                else          dq.push_back(e);
            end
            if (!m_lock) begin
                if (win == 2 || !dv)                    m_hold = 0;
                else if (win == 1 && m_hold < MAX_HOLD) m_hold++;
            end
            if (win == 2) m_lock = LOCK_EN && lk;
        end
        prev_rst = r;
    endtask

    // Monitor: compares every response slot against the scoreboard queues.
    always @(negedge clk) begin
        exp_t e;
        bit   ev;
        while (cq.size() != 0 && cq[0].due < cyc) e = cq.pop_front();
        while (dq.size() != 0 && dq[0].due < cyc) e = dq.pop_front();
        ev = (cq.size() != 0 && cq[0].due == cyc);
        check("c_rsp_valid", 64'(c_rsp_valid), 64'(ev));
        if (ev) begin
            e = cq.pop_front();
            check("c_rsp_rdata", c_rsp_rdata, e.data);
        end
        ev = (dq.size() != 0 && dq[0].due == cyc);
        check("d_rsp_valid", 64'(d_rsp_valid), 64'(ev));
        if (ev) begin
            e = dq.pop_front();
            check("d_rsp_rdata", d_rsp_rdata, e.data);
        end
    end

    function automatic tb_req_t rnd_req();
        tb_req_t q;
        q.write = 1'($urandom_range(0, 1));
        q.f3    = 3'($urandom_range(0, 7));
        q.addr  = {55'd0, 6'($urandom_range(0, 63)), 3'd0};
        q.wdata = {$urandom, $urandom};
        return q;
    endfunction

    function automatic tb_req_t mk(input logic w, input logic [2:0] f3,
                                   input logic [63:0] a, input logic [63:0] wd);
        tb_req_t q;
        q.write = w;
        q.f3    = f3;
        q.addr  = a;
        q.wdata = wd;
        return q;
    endfunction

    initial begin
        tb_req_t z, cr, dr;
        int      first_d;
        bit      c_pend, d_pend, cv, dv, lk, rr;
        z = '0;

        // Reset, with a core request present to prove outputs stay gated.
        step(1, 0, z, 0, z, 0);
        step(1, 1, mk(0, 3'b011, 64'h10, 0), 1, z, 0);
        step(0, 1, mk(0, 3'b011, 64'h10, 0), 0, z, 0);
        check("post_rst_c_ready", 64'(c_req_ready), 64'(0));

        // Core-only load of a preset word.
        step(0, 1, mk(0, 3'b011, 64'h10, 0), 0, z, 0);
        check("core_load_ready", 64'(c_req_ready), 64'(1));
        step(0, 0, z, 0, z, 0);
        check("core_load_data", c_rsp_rdata, 64'hDEADBEEF_00000001);
        check("core_load_no_d", 64'(d_rsp_valid), 64'(0));

        // DMA store then core load of the same word.
        step(0, 0, z, 1, mk(1, 3'b011, 64'h20, 64'h55), 0);
        step(0, 1, mk(0, 3'b011, 64'h20, 0), 0, z, 0);
        check("dma_store_rdata", d_rsp_rdata, 64'd0);
        step(0, 0, z, 0, z, 0);
        check("core_after_dma", c_rsp_rdata, 64'h55);

        // Continuous contention: DMA first wins in the (MAX_HOLD+1)th cycle.
        cr = mk(0, 3'b000, 64'h40, 0);
        dr = mk(1, 3'b011, 64'h48, 64'h1234);
        step(0, 0, z, 0, z, 0);
        first_d = 0;
        for (int i = 1; i <= 2 * MAX_HOLD + 4; i++) begin
            step(0, 1, cr, 1, dr, 0);
            if (first_d == 0 && d_req_ready) first_d = i;
        end
        check("first_dma_grant", 64'(first_d), 64'(MAX_HOLD + 1));

        // A one-cycle DMA valid drop restarts the starvation count.
        step(0, 0, z, 0, z, 0);
        for (int i = 0; i < 4; i++) step(0, 1, cr, 1, dr, 0);
        step(0, 1, cr, 0, dr, 0);
        first_d = 0;
        for (int i = 1; i <= MAX_HOLD + 4; i++) begin
            step(0, 1, cr, 1, dr, 0);
            if (first_d == 0 && d_req_ready) first_d = i;
        end
        check("dma_after_drop", 64'(first_d), 64'(MAX_HOLD + 1));

        // Reset right after an accepted load drops its response.
        step(0, 0, z, 0, z, 0);
        step(0, 1, mk(0, 3'b011, 64'h18, 0), 0, z, 0);
        check("rst_drop_accept", 64'(c_req_ready), 64'(1));
        step(1, 0, z, 0, z, 0);
        check("rst_drop_rsp", 64'(c_rsp_valid), 64'(0));
        step(0, 1, mk(0, 3'b011, 64'h18, 0), 0, z, 0);
        check("rst_drop_block", 64'(c_req_ready), 64'(0));
        step(0, 0, z, 0, z, 0);

        // Randomized traffic; requests stay stable while pending.
        c_pend = 1'b0;
        d_pend = 1'b0;
        cv = 1'b0;
        dv = 1'b0;
        cr = z;
        dr = z;
        for (int i = 0; i < 1500; i++) begin
            if (!c_pend || $urandom_range(0, 9) == 0) begin
                cr = rnd_req();
                cv = ($urandom_range(0, 99) < 70);
            end
            if (!d_pend || $urandom_range(0, 9) == 0) begin
                dr = rnd_req();
                dv = ($urandom_range(0, 99) < 60);
            end
            lk = ($urandom_range(0, 3) == 0);
            rr = ($urandom_range(0, 299) == 0);
            step(rr, cv, cr, dv, dr, lk);
            c_pend = cv && !c_req_ready && !rr;
            d_pend = dv && !d_req_ready && !rr;
        end
        for (int i = 0; i < 4; i++) step(0, 0, z, 0, z, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port (data_mem64) between the core load/store path and a DMA/debug loader port. Each port uses a valid/ready request and a registered one-cycle response. Core priority is the default, with a starvation bound for DMA. The block sits between the core datapath (ALU address, regB write data, funct3) and data_mem64; the core stalls its PC while c_req_ready is low.

## Interface
- ADDR_W, 64, request address width
- DATA_W, 64, data width
- MAX_HOLD, 8, max consecutive core grants while DMA is pending (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- c_req_valid  in  1  core request
- c_req_ready  out  1  core request accepted this cycle
- c_req_write  in  1  1=store, 0=load
- c_req_funct3  in  3  access size/sign, passed to memory
- c_req_addr  in  ADDR_W  byte address
- c_req_wdata  in  DATA_W  store data
- c_rsp_valid  out  1  response for core beat accepted previous cycle
- c_rsp_rdata  out  DATA_W  load data (0 for stores)
- d_req_valid, d_req_ready, d_req_write, d_req_funct3, d_req_addr, d_req_wdata, d_rsp_valid, d_rsp_rdata: same as the core port, for DMA
- d_req_lock  in  1  hold grant after this beat (only with DMEM_ARB_LOCK_EN)
- m_memread  out  1  to data_mem64 memread
- m_memwrite  out  1  to data_mem64 memwrite
- m_funct3  out  3  to data_mem64 funct3
- m_addr  out  ADDR_W  to data_mem64 addr
- m_wdata  out  DATA_W  to data_mem64 wdata
- m_rdata  in  DATA_W  from data_mem64 rdata (combinational read)
- grant  out  2  one-hot {dma, core} beat issued this cycle

## Operation
- At most one beat is issued per cycle. x_req_ready = grant bit (combinational from valid, state and counter); the beat is accepted when valid & ready.
- Default priority: core wins when both are valid.
- Starvation counter hold_cnt:
  - Increments on each core grant while d_req_valid=1.
  - Clears on any DMA grant, or on any cycle with d_req_valid=0.
  - When hold_cnt == MAX_HOLD and both ports are valid, DMA wins.
  - hold_cnt saturates at MAX_HOLD.
- Memory drive:
  - The granted port's funct3, addr and wdata go to m_*; m_memread = granted & ~write; m_memwrite = granted & write.
  - With no grant, m_memread = m_memwrite = 0 and m_addr, m_wdata and m_funct3 are 0.
- Response:
  - The accepted beat's port and direction are registered.
  - The next cycle pulses x_rsp_valid for one cycle. x_rsp_rdata = the m_rdata registered at acceptance for loads, 0 for stores.
  - Back-to-back beats give back-to-back responses.
- Requesters hold all request fields stable while valid & ~ready. The arbiter does not check this.
- States: ARB (normal) and LOCK (macro only, see Configuration).

## Timing
- Request→memory: 0 cycles, combinational. Accept→rsp_valid: exactly 1 cycle.
- Throughput: 1 beat/cycle in total.
- During reset all outputs are 0, and they stay 0 in the first cycle after rst deasserts.
- Reset clears hold_cnt, state=ARB and the response registers. A response pending at reset is dropped.
- Simultaneous valid with hold_cnt<MAX_HOLD: core granted. With hold_cnt==MAX_HOLD: DMA granted, and hold_cnt clears the following cycle.
- Valid dropped without acceptance: legal, no state change.

## Configuration
- Macro: DMEM_ARB_LOCK_EN.
- Defined:
  - d_req_lock port exists.
  - An accepted DMA beat with lock=1 moves the state to LOCK.
  - In LOCK only DMA is granted; c_req_ready=0 and hold_cnt is frozen.
  - An accepted DMA beat with lock=0 returns the state to ARB.
  - d_req_valid=0 in LOCK keeps LOCK.
- Undefined: no d_req_lock port, no LOCK state; behaviour is ARB only.

## Structure
- Package dmem_arb_pkg:
  - state enum (ARB, LOCK)
  - port index constants (PORT_CORE=0, PORT_DMA=1)
  - a request struct typedef {write, funct3, addr, wdata}
- One sub-module, dmem_arb_prio: combinational grant from {c_valid, d_valid, hold_cnt==MAX_HOLD, state}. The top level holds the counter, state, muxing and response registers.

## Test plan
- Core only: load addr 0x10 with funct3=3'b011, mem holds 0xDEADBEEF_00000001 → c_req_ready=1 same cycle, c_rsp_valid next cycle with that data; d_rsp_valid=0.
- Both valid continuously, MAX_HOLD=8 → grant pattern: 8 core beats, 1 DMA beat, repeating; d_req_ready first high in cycle 9.
- DMA store 0x55 to 0x20, then core load 0x20 the next cycle → core reads 0x55. d_rsp_valid pulses with rdata 0.
- Reset asserted in the cycle after a core load is accepted → no c_rsp_valid; all outputs 0 during reset and the first cycle after.
- DMEM_ARB_LOCK_EN: DMA 3 beats with lock=1,1,0 while core valid → core stalled 3 cycles, granted in cycle 4.
- Both valid, DMA drops valid for 1 cycle mid-run → hold_cnt resets; the next DMA grant needs 8 more core beats.
